mips32_hazard_ctrl: RTL

//  Interlock controller for pipe_MIPS32. It replaces hand-inserted dummy instructions (OR R3,R3,R3) in programs.

---
 rtl/mips32_hazard_ctrl_if.sv | 43 ++++
 rtl/mips32_hazard_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mips32_hazard_ctrl_if.sv
// Purpose: groups the ID-stage hazard inputs and the interlock outputs of
// mips32_hazard_ctrl into one bundle.
//   master : the pipeline side; drives the ID instruction fields and ex_taken,
//            and receives the interlock controls.
//   slave  : the interlock controller.
// Signals:
//   id_valid/id_rs/id_rt/id_use_rs/id_use_rt/id_wr/id_rd/id_hlt : ID instruction
//   ex_taken   : branch resolved taken in EX this cycle
//   stall      : hold PC and IF/ID
//   bubble     : load NOP into ID/EX
//   flush      : squash IF/ID
//   halted     : sticky halted flag
//   stall_cnt  : saturating count of RAW stall cycles
interface mips32_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wr;
  logic [4:0]       id_rd;
  logic             id_hlt;
  logic             ex_taken;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_hlt,
    output ex_taken,
    input  stall, bubble, flush, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_hlt,
    input  ex_taken,
    output stall, bubble, flush, halted, stall_cnt
  );
endinterface

// File: rtl/mips32_hazard_ctrl.sv
// Purpose: interlock controller for pipe_MIPS32. A shift-register scoreboard
// remembers the destination registers of the last HAZ_DEPTH issued
// instructions; an ID instruction reading one of them is held (stall) while a
// NOP is pushed into ID/EX (bubble). A taken branch squashes IF/ID (flush).
// An issued HLT drains the pipe for HAZ_DEPTH cycles and then parks the
// controller in a sticky halted state that only rst leaves.
// Ports:
//   clk1 : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   hz   : slave side of mips32_hazard_ctrl_if (ID fields, ex_taken in;
//          stall/bubble/flush comb out, halted/stall_cnt registered out)
module mips32_hazard_ctrl #(
  parameter int HAZ_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic                  clk1,
  input  logic                  rst,
  mips32_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [2:0]                    dcnt_q, dcnt_d;
  logic                          halted_q, halted_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [HAZ_DEPTH-1:0]          slot_v_q;
  logic [HAZ_DEPTH-1:0][4:0]     slot_rd_q;

  logic hazard;
  logic issue;
  logic stall, bubble, flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Slots only ever hold nonzero rd, so a read of R0 can never match.
  always_comb begin
    hazard = 1'b0;
    if (hz.id_valid && state_q == ST_RUN) begin
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        if (slot_v_q[i] &&
            ((hz.id_use_rs && hz.id_rs == slot_rd_q[i]) ||
             (hz.id_use_rt && hz.id_rt == slot_rd_q[i])))
          hazard = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;
    issue    = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A taken branch outranks a RAW stall: the ID instruction is wrong-path.
        flush  = hz.ex_taken;
        stall  = hazard & ~hz.ex_taken;
        bubble = hazard | hz.ex_taken;
        issue  = hz.id_valid & ~hazard & ~hz.ex_taken;
        if (stall)
          cnt_d = sat_inc(cnt_q);
        if (issue && hz.id_hlt) begin
          state_d = ST_DRAIN;
          dcnt_d  = 3'(HAZ_DEPTH - 1);
        end
      end
      ST_DRAIN: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (dcnt_q == 3'd0) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q - 3'd1;
        end
      end
      ST_HALTED: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      stall  = 1'b0;
      flush  = 1'b0;
      bubble = 1'b1;
      issue  = 1'b0;
    end
  end

  // Control state and scoreboard valid bits
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= ST_RUN;
      dcnt_q   <= 3'd0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      slot_v_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
      slot_v_q[0] <= issue & hz.id_wr & (hz.id_rd != 5'd0);
      for (int i = 1; i < HAZ_DEPTH; i++)
        slot_v_q[i] <= slot_v_q[i-1];
    end
  end

  // Scoreboard register numbers; meaningful only where the valid bit is set
  always_ff @(posedge clk1) begin
    slot_rd_q[0] <= hz.id_rd;
    for (int i = 1; i < HAZ_DEPTH; i++)
      slot_rd_q[i] <= slot_rd_q[i-1];
  end

  assign hz.stall     = stall;
  assign hz.bubble    = bubble;
  assign hz.flush     = flush;
  assign hz.halted    = halted_q;
  assign hz.stall_cnt = cnt_q;

endmodule
